// File: rtl/line_dma_writer.sv
// Multi-command DMA write master: queues (address, size) buffer commands and drains a
// show-ahead FIFO into an Avalon-MM write port as bursts of up to BURST_MAX words.
// Latency: command accepted at edge N, popped at N+1, first SDRAM_WRITE from N+2 when data is present.
// Backpressure: CMD_READY drops when the queue is full; SDRAM_WAITREQUEST stalls beats; a burst only starts once the FIFO holds all its beats.
//
// Ports: CLK/RST (async active-high); CMD_ADR/CMD_SIZE/CMD_VALID/CMD_READY command queue;
// ABORT drops queue and current buffer; BUSY, DONE_CNT status; FIFO_* show-ahead FIFO read
// side; SDRAM_* Avalon-MM write master.
// Optional macro LINE_DMA_HWSWAP_EN: swap the 16-bit halves of every 32-bit write-data lane.
module line_dma_writer #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 28,
    parameter int CMD_DEPTH = 4,
    parameter int BURST_MAX = 16,
    parameter int FCNT_W    = 11,
    parameter int CNT_W     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   CMD_ADR,
    input  logic [ADDR_W-1:0]   CMD_SIZE,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic                ABORT,
    output logic                BUSY,
    output logic [CNT_W-1:0]    DONE_CNT,
    input  logic [DATA_W-1:0]   FIFO_DATA,
    input  logic                FIFO_EMPTY,
    input  logic [FCNT_W-1:0]   FIFO_DATA_CNT,
    output logic                FIFO_RD_EN,
    output logic [ADDR_W-1:0]   SDRAM_ADDRESS,
    output logic [7:0]          SDRAM_BURSTCOUNT,
    output logic [DATA_W-1:0]   SDRAM_WRITEDATA,
    output logic [DATA_W/8-1:0] SDRAM_BYTEENABLE,
    output logic                SDRAM_WRITE,
    input  logic                SDRAM_WAITREQUEST
);
    localparam int QAW  = $clog2(CMD_DEPTH);
    localparam int CMPW = (ADDR_W > FCNT_W) ? ADDR_W : FCNT_W;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BURST, S_DONE} state_t;

    state_t            state, state_nxt;

    logic [ADDR_W-1:0] q_adr  [CMD_DEPTH];
    logic [ADDR_W-1:0] q_size [CMD_DEPTH];
    logic [QAW-1:0]    q_wr, q_rd;
    logic [QAW:0]      q_cnt, q_cnt_nxt;
    logic              cmd_rdy;

    logic              push, pop, load, last, done_inc, beat, write;
    logic [ADDR_W-1:0] cur_adr, cur_rem, len;
    logic [CMPW-1:0]   fcnt_ext, len_ext;
    logic [7:0]        beat_cnt, bcnt;
    logic [ADDR_W-1:0] adr_out;
    logic              abort_pend;
    logic [CNT_W-1:0]  done_cnt;

    // A command arriving in the ABORT cycle is dropped along with the queue.
    assign push      = CMD_VALID & cmd_rdy & ~ABORT;
    assign q_cnt_nxt = ABORT ? '0 : (q_cnt + {{QAW{1'b0}}, push} - {{QAW{1'b0}}, pop});

    assign len      = (cur_rem > ADDR_W'(BURST_MAX)) ? ADDR_W'(BURST_MAX) : cur_rem;
    assign fcnt_ext = CMPW'(FIFO_DATA_CNT);
    assign len_ext  = CMPW'(len);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        last      = 1'b0;
        done_inc  = 1'b0;
        write     = (state == S_BURST);
        beat      = write & ~SDRAM_WAITREQUEST;
        case (state)
            S_IDLE: begin
                if (!ABORT && q_cnt != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (ABORT) begin
                    state_nxt = S_IDLE;
                end else if (cur_rem == '0) begin
                    state_nxt = S_DONE;
                end else if (!FIFO_EMPTY && fcnt_ext >= len_ext) begin
                    // Every beat of the burst is already in the FIFO: no mid-burst underrun.
                    load      = 1'b1;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (beat && beat_cnt == 8'd1) begin
                    last      = 1'b1;
                    state_nxt = (abort_pend || ABORT) ? S_IDLE : S_CHECK;
                end
            end
            S_DONE: begin
                done_inc  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Queue storage needs no reset; only pointers and count define its contents.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_adr[q_wr]  <= CMD_ADR;
            q_size[q_wr] <= CMD_SIZE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_wr    <= '0;
            q_rd    <= '0;
            q_cnt   <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            q_cnt   <= q_cnt_nxt;
            cmd_rdy <= (q_cnt_nxt < (QAW+1)'(CMD_DEPTH));
            if (push) q_wr <= q_wr + 1'b1;
            if (ABORT)    q_rd <= q_wr;
            else if (pop) q_rd <= q_rd + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_adr    <= '0;
            cur_rem    <= '0;
            adr_out    <= '0;
            bcnt       <= '0;
            beat_cnt   <= '0;
            abort_pend <= 1'b0;
            done_cnt   <= '0;
        end else begin
            if (pop) begin
                cur_adr <= q_adr[q_rd];
                cur_rem <= q_size[q_rd];
            end
            if (load) begin
                adr_out  <= cur_adr;
                bcnt     <= 8'(len);
                beat_cnt <= 8'(len);
            end else if (beat) begin
                beat_cnt <= beat_cnt - 8'd1;
            end
            if (last) begin
                cur_adr <= cur_adr + ADDR_W'(bcnt);
                cur_rem <= cur_rem - ADDR_W'(bcnt);
            end
            // An abort seen mid-burst is remembered until the burst's last beat.
            if (last)                            abort_pend <= 1'b0;
            else if (ABORT && state == S_BURST)  abort_pend <= 1'b1;
            if (done_inc) done_cnt <= done_cnt + 1'b1;
        end
    end

`ifdef LINE_DMA_HWSWAP_EN
    always_comb begin
        SDRAM_WRITEDATA = FIFO_DATA;
        for (int i = 0; i < DATA_W/32; i++) begin
            SDRAM_WRITEDATA[32*i +: 32] = {FIFO_DATA[32*i +: 16], FIFO_DATA[32*i+16 +: 16]};
        end
    end
`else
    assign SDRAM_WRITEDATA = FIFO_DATA;
`endif

    assign CMD_READY        = cmd_rdy;
    assign BUSY             = (state != S_IDLE) | (q_cnt != '0);
    assign DONE_CNT         = done_cnt;
    assign SDRAM_WRITE      = write;
    assign FIFO_RD_EN       = beat;
    assign SDRAM_ADDRESS    = adr_out;
    assign SDRAM_BURSTCOUNT = bcnt;
    assign SDRAM_BYTEENABLE = '1;
endmodule
